// File: rtl/sdm_cic_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, saturated signed PCM out.
// A one-entry valid/ready buffer holds the newest sample; a sample replaced before
// it was taken sets a sticky overrun flag.
module sdm_cic_decimator #(
  parameter int LOG2R     = 6,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        BIT_IN,
  input  logic                        OUT_READY,
  output logic signed [OUT_WIDTH-1:0] OUT_DATA,
  output logic                        OUT_VALID,
  output logic                        OVERRUN
);

  localparam int W       = 3*LOG2R + 2;
  localparam int SHIFT   = 3*LOG2R + 1 - OUT_WIDTH;
  localparam int SAT_HI  = (1 << (OUT_WIDTH-1)) - 1;
  localparam int SAT_LO  = -(1 << (OUT_WIDTH-1));
  localparam logic signed [W-1:0] SAT_MAX = W'(SAT_HI);
  localparam logic signed [W-1:0] SAT_MIN = W'(SAT_LO);

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, i3;
  logic [LOG2R-1:0]    cnt;
  logic                tick;
  logic [2:0]          settle;
  logic                settled;
  logic signed [W-1:0] d, d_prev, c1, c1_prev, c2, c2_prev, c3;
  logic [3:0]          adv;
  logic [3:0]          keep;
  logic signed [W-1:0] c3_sh;
  logic signed [OUT_WIDTH-1:0] sat_val;

  assign x       = BIT_IN ? W'(1) : {W{1'b1}};
  assign tick    = (cnt == {LOG2R{1'b1}});
  assign settled = (settle == 3'd4);

  // Integrator chain, one update per input bit; wrap-around is harmless to the combs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + x;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Decimation counter and settle count; the first four decimated samples are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      settle <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick && !settled) settle <= settle + 3'd1;
    end
  end

  // Capture i3 on tick and run the three comb stages, each advancing once per sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d       <= '0;
      d_prev  <= '0;
      c1      <= '0;
      c1_prev <= '0;
      c2      <= '0;
      c2_prev <= '0;
      c3      <= '0;
      adv     <= '0;
      keep    <= '0;
    end else begin
      adv  <= {adv[2:0], tick};
      keep <= {keep[2:0], settled};
      if (tick) d <= i3;
      if (adv[0]) begin
        c1     <= d - d_prev;
        d_prev <= d;
      end
      if (adv[1]) begin
        c2      <= c1 - c1_prev;
        c1_prev <= c1;
      end
      if (adv[2]) begin
        c3      <= c2 - c2_prev;
        c2_prev <= c2;
      end
    end
  end

  // Scale and saturate the comb output into the PCM range.
  always_comb begin
    c3_sh = c3 >>> SHIFT;
    if (c3_sh > SAT_MAX)      sat_val = OUT_WIDTH'(SAT_HI);
    else if (c3_sh < SAT_MIN) sat_val = OUT_WIDTH'(SAT_LO);
    else                      sat_val = c3_sh[OUT_WIDTH-1:0];
  end

  // One-entry output buffer; a new sample always wins, flagging overrun if unread.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (adv[3] && keep[3]) begin
      OUT_DATA  <= sat_val;
      OUT_VALID <= 1'b1;
      if (OUT_VALID && !OUT_READY) OVERRUN <= 1'b1;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Bench for sdm_cic_decimator: an FIR-form reference (triple boxcar over the bit
// history) feeds a scoreboard; a monitor models the output buffer and compares.
module tb_sdm_cic_decimator;

  localparam int LOG2R     = 6;
  localparam int R         = 1 << LOG2R;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = 3*LOG2R + 1 - OUT_WIDTH;
  localparam int NTAP      = 3*R - 2;
  localparam int HMAX      = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic BIT_IN = 1'b1;
  logic OUT_READY = 1'b1;
  logic signed [OUT_WIDTH-1:0] OUT_DATA;
  logic OUT_VALID;
  logic OVERRUN;

  sdm_cic_decimator #(.LOG2R(LOG2R), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk(clk), .rst(rst), .BIT_IN(BIT_IN), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int h2[NTAP];
  int h[NTAP];
  logic hist[0:HMAX-1];
  int kc = 0;
  int pidx = 0;

  typedef struct { int val; int arr; } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Impulse response of three cascaded length-R boxcars.
  initial begin
    for (int j = 0; j < NTAP; j++) begin
      h2[j] = 0;
      for (int i = 0; i < R; i++) if (j - i >= 0 && j - i < R) h2[j] += 1;
    end
    for (int j = 0; j < NTAP; j++) begin
      h[j] = 0;
      for (int i = 0; i < R; i++) if (j - i >= 0 && j - i <= 2*R - 2) h[j] += h2[j-i];
    end
  end

  // Decimated sample at input edge k: weighted sum of bits ending 3 edges earlier.
  function automatic int ref_sample(input int k);
    int acc = 0;
    for (int j = 0; j < NTAP; j++) acc += h[j] * (hist[k-3-j] ? 1 : -1);
    acc = acc >>> SHIFT;
    if (acc > (1 << (OUT_WIDTH-1)) - 1) acc = (1 << (OUT_WIDTH-1)) - 1;
    if (acc < -(1 << (OUT_WIDTH-1)))    acc = -(1 << (OUT_WIDTH-1));
    return acc;
  endfunction

  // Stimulus side of the scoreboard: record bits, push each kept sample with its arrival edge.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      kc = 0;
      sbq.delete();
    end else begin
      kc++;
      hist[kc] = BIT_IN;
      if (kc % R == 0 && kc / R >= 5) sbq.push_back('{ref_sample(kc), kc + 4});
    end
  end

  // Monitor: apply the buffer rules to arriving expectations and compare every cycle.
  initial begin
    logic e_valid, e_ovr, arrived;
    int e_data, nv;
    e_valid = 0; e_ovr = 0; e_data = 0; nv = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        e_valid = 0; e_ovr = 0; e_data = 0;
      end else begin
        arrived = 0;
        while (sbq.size() > 0 && sbq[0].arr <= kc) begin
          nv = sbq[0].val;
          void'(sbq.pop_front());
          arrived = 1;
        end
        if (arrived) begin
          if (e_valid && !OUT_READY) e_ovr = 1;
          e_data  = nv;
          e_valid = 1;
        end else if (e_valid && OUT_READY) begin
          e_valid = 0;
        end
      end
      check("mon_valid", OUT_VALID, e_valid);
      check("mon_overrun", OVERRUN, e_ovr);
      check("mon_data", OUT_DATA, e_data);
    end
  end

  function automatic logic pat_bit(input int mode, input int p);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (p % 4) != 3;
      3:       return (p % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // rmode: 0 ready high, 1 ready low, 2 random, 3 pulse on each load edge.
  task automatic drive(input int n, input int mode, input int rmode);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      BIT_IN = pat_bit(mode, pidx);
      pidx++;
      case (rmode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = 1'b0;
        2:       OUT_READY = 1'($urandom_range(0, 1));
        default: OUT_READY = ((kc + 1) % R == 4);
      endcase
    end
  endtask

  // Called right after reset release: the first valid must appear at edge 5R+4.
  task automatic first_valid(input int mode);
    int found = 0;
    for (int c = 1; c <= 6*R && found == 0; c++) begin
      @(negedge clk);
      if (OUT_VALID) found = c;
      BIT_IN = pat_bit(mode, pidx);
      pidx++;
      OUT_READY = 1'b1;
    end
    check("first_valid_edge", found, 5*R + 4);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_valid"}, OUT_VALID, 0);
    check({tag, "_overrun"}, OVERRUN, 0);
    check({tag, "_data"}, OUT_DATA, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int waited;
    rst = 1'b0;
    BIT_IN = 1'b1;
    OUT_READY = 1'b1;
    repeat (3) @(negedge clk);
    check("init_valid", OUT_VALID, 0);
    check("init_overrun", OVERRUN, 0);
    check("init_data", OUT_DATA, 0);
    rst = 1'b1;

    first_valid(0);
    drive(10*R, 0, 0);
    check("ones_data", OUT_DATA, 32767);
    drive(8*R, 1, 0);
    check("zeros_data", OUT_DATA, -32768);
    drive(8*R, 2, 0);
    check("p1110_data", OUT_DATA, 16384);
    drive(8*R, 3, 0);
    check("p1010_data", OUT_DATA, 0);
    drive(20*R, 4, 2);

    // Reset while the newest captured sample is still inside the comb pipeline.
    waited = 0;
    while (kc % R != 2 && waited < 2*R) begin
      drive(1, 4, 2);
      waited++;
    end
    check("midreset_sync", kc % R, 2);
    do_reset("midreset");
    first_valid(2);

    drive(4*R, 2, 0);
    drive(200, 2, 1);
    check("bp_overrun", OVERRUN, 1);
    check("bp_data", OUT_DATA, 16384);
    drive(3, 2, 0);
    check("bp_overrun_sticky", OVERRUN, 1);

    do_reset("reset2");
    first_valid(2);
    drive(10*R, 2, 3);
    check("pulse_overrun", OVERRUN, 0);
    check("pulse_valid", OUT_VALID, 1);
    check("pulse_data", OUT_DATA, 16384);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
